// File: rtl/perf_csr_port.sv
// CSR-side port onto the performance counter bank: lo/hi counter reads with a
// high-half shadow for consistent 64-bit reads, plus the mcountinhibit register.
module perf_csr_port #(
    parameter int NUM_CNT = 3,
    parameter int XLEN    = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clk_en,
    input  logic [NUM_CNT-1:0][XLEN-1:0]    cnt_lo,
    input  logic [NUM_CNT-1:0][XLEN-1:0]    cnt_hi,
    output logic [NUM_CNT-1:0]              cnt_enable,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [11:0]                     req_addr,
    input  logic                            req_we,
    input  logic [XLEN-1:0]                 req_wdata,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [XLEN-1:0]                 rsp_rdata,
    output logic                            rsp_err
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
    localparam logic [11:0] ADDR_LO_BASE = 12'hC00;
    localparam logic [11:0] ADDR_HI_BASE = 12'hC80;

    state_t                         state;
    logic [NUM_CNT-1:0]             inhibit;
    logic [NUM_CNT-1:0][XLEN-1:0]   shadow_hi;
    logic [NUM_CNT-1:0]             shadow_vld;

    logic [NUM_CNT-1:0]             lo_hit;
    logic [NUM_CNT-1:0]             hi_hit;
    logic                           inh_hit;
    logic [NUM_CNT-1:0]             inh_wr;
    logic [XLEN-1:0]                nxt_rdata;
    logic                           nxt_err;
    logic                           unused_wdata;

    assign req_ready    = (state == IDLE);
    assign cnt_enable   = ~inhibit;
    assign inh_hit      = (req_addr == ADDR_INHIBIT);
    assign unused_wdata = ^(req_wdata >> NUM_CNT);

    // Hits are only raised for reads; counter-range writes fall through to the error path.
    always_comb begin
        lo_hit = '0;
        hi_hit = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            lo_hit[i] = !req_we && (req_addr == ADDR_LO_BASE + 12'(i));
            hi_hit[i] = !req_we && (req_addr == ADDR_HI_BASE + 12'(i));
        end
    end

    always_comb begin
        inh_wr    = req_wdata[NUM_CNT-1:0];
        inh_wr[1] = 1'b0;
        nxt_rdata = '0;
        nxt_err   = 1'b0;
        if (inh_hit) begin
            if (!req_we)
                nxt_rdata = XLEN'(inhibit);
        end else if (|lo_hit) begin
            for (int unsigned i = 0; i < NUM_CNT; i++)
                if (lo_hit[i])
                    nxt_rdata = cnt_lo[i];
        end else if (|hi_hit) begin
            for (int unsigned i = 0; i < NUM_CNT; i++)
                if (hi_hit[i])
                    nxt_rdata = shadow_vld[i] ? shadow_hi[i] : cnt_hi[i];
        end else begin
            nxt_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            inhibit    <= '0;
            shadow_hi  <= '0;
            shadow_vld <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= nxt_rdata;
                        rsp_err   <= nxt_err;
                        if (inh_hit && req_we)
                            inhibit <= inh_wr;
                        for (int unsigned i = 0; i < NUM_CNT; i++) begin
                            if (lo_hit[i]) begin
                                shadow_hi[i]  <= cnt_hi[i];
                                shadow_vld[i] <= 1'b1;
                            end else if (hi_hit[i]) begin
                                shadow_vld[i] <= 1'b0;
                            end
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_csr_port.sv
// Randomized scoreboard bench for perf_csr_port against a behavioural CSR model.
module tb_perf_csr_port;

    localparam int N = 3;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clk_en;
    logic [N-1:0][31:0]   cnt_lo;
    logic [N-1:0][31:0]   cnt_hi;
    logic [N-1:0]         cnt_enable;
    logic                 req_valid;
    logic                 req_ready;
    logic [11:0]          req_addr;
    logic                 req_we;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    perf_csr_port #(.NUM_CNT(N), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .cnt_lo(cnt_lo), .cnt_hi(cnt_hi), .cnt_enable(cnt_enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          ready_mode = 0;   // 0 random, 1 held low, 2 held high
    exp_t        sb[$];

    // Reference model state
    logic [N-1:0] inh_m;
    logic [31:0]  sh_m [N];
    bit           shv_m [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        inh_m = '0;
        for (int i = 0; i < N; i++) begin
            sh_m[i]  = '0;
            shv_m[i] = 0;
        end
    endtask

    function automatic exp_t model_access(input logic [11:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        int   k;
        e.rdata = '0;
        e.err   = 1'b0;
        if (a == 12'h320) begin
            if (w) inh_m = d[N-1:0] & 3'b101;
            else   e.rdata = {29'd0, inh_m};
        end else if (w) begin
            e.err = 1'b1;
        end else if (a >= 12'hC00 && int'(a) < 'hC00 + N) begin
            k = int'(a) - 'hC00;
            e.rdata  = cnt_lo[k];
            sh_m[k]  = cnt_hi[k];
            shv_m[k] = 1;
        end else if (a >= 12'hC80 && int'(a) < 'hC80 + N) begin
            k = int'(a) - 'hC80;
            e.rdata  = shv_m[k] ? sh_m[k] : cnt_hi[k];
            shv_m[k] = 0;
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    // Monitor: drives rsp_ready and pops the scoreboard on each completed handshake.
    always @(negedge clk) begin
        exp_t e;
        case (ready_mode)
            1:       rsp_ready = 1'b0;
            2:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (rst_n && rsp_valid && rsp_ready && clk_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic do_req(input logic [11:0] a, input logic w, input logic [31:0] d, input bit wait_rsp);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = w;
        req_wdata = d;
        while (!(req_ready && clk_en) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back(model_access(a, w, d));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("latency_valid", {31'd0, rsp_valid}, 32'd1);
        chk("cnt_enable", {29'd0, cnt_enable}, {29'd0, ~inh_m});
        if (wait_rsp) drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        logic [31:0] exp_lo;
        int          r;

        rst_n = 1'b0; clk_en = 1'b1; req_valid = 1'b0; req_addr = '0;
        req_we = 1'b0; req_wdata = '0; cnt_lo = '0; cnt_hi = '0;
        model_reset();
        #1;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_cnt_enable", {29'd0, cnt_enable}, 32'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Inhibit register read, write, read-back
        do_req(12'h320, 1'b0, 32'd0, 1);
        do_req(12'h320, 1'b1, 32'hFFFF_FFFF, 1);
        chk("inhibit_enable", {29'd0, cnt_enable}, 32'h2);
        do_req(12'h320, 1'b0, 32'd0, 1);

        // Wrap between lo and hi reads
        cnt_lo[0] = 32'hFFFF_FFFF; cnt_hi[0] = 32'h7;
        do_req(12'hC00, 1'b0, 32'd0, 1);
        cnt_lo[0] = 32'h0; cnt_hi[0] = 32'h8;
        do_req(12'hC80, 1'b0, 32'd0, 1);
        do_req(12'hC80, 1'b0, 32'd0, 1);

        // Illegal accesses
        do_req(12'hC02, 1'b1, 32'h1234_5678, 1);
        do_req(12'hC05, 1'b0, 32'd0, 1);
        do_req(12'h320, 1'b0, 32'd0, 1);

        // Back-pressure: response must hold while counters move
        ready_mode = 1;
        cnt_lo[1] = $urandom;
        exp_lo = cnt_lo[1];
        do_req(12'hC01, 1'b0, 32'd0, 0);
        for (int i = 0; i < 5; i++) begin
            cnt_lo[1] = $urandom;
            @(posedge clk); #1;
            chk("stall_rdata", rsp_rdata, exp_lo);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        ready_mode = 0;
        drain();

        // clk_en low blocks acceptance
        @(posedge clk); #1;
        clk_en = 1'b0; req_valid = 1'b1; req_addr = 12'h320; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("clken_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 1'b0; clk_en = 1'b1;
        @(posedge clk); #1;
        chk("clken_no_rsp_after", {31'd0, rsp_valid}, 32'd0);

        // clk_en low freezes a pending response even with rsp_ready high
        ready_mode = 2;
        do_req(12'hC82, 1'b0, 32'd0, 0);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("clken_hold_valid", {31'd0, rsp_valid}, 32'd1);
        end
        clk_en = 1'b1;
        drain();
        ready_mode = 0;

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, N - 1);
                cnt_lo[r] = $urandom;
                cnt_hi[r] = $urandom;
            end
            case ($urandom_range(0, 8))
                0, 1:    a = 12'hC00 + 12'($urandom_range(0, N - 1));
                2, 3:    a = 12'hC80 + 12'($urandom_range(0, N - 1));
                4:       a = 12'h320;
                5:       a = 12'hC00 + 12'($urandom_range(N, 31));
                6:       a = 12'hC80 + 12'($urandom_range(N, 31));
                7:       a = 12'($urandom);
                default: a = 12'hC00 + 12'($urandom_range(0, 159));
            endcase
            do_req(a, ($urandom_range(0, 3) == 0), $urandom, 1);
        end

        // Reset while a response is pending
        do_req(12'h320, 1'b1, 32'h5, 1);
        cnt_hi[1] = 32'hAAAA_0001;
        do_req(12'hC01, 1'b0, 32'd0, 1);
        cnt_hi[1] = 32'hAAAA_0002;
        ready_mode = 1;
        do_req(12'h320, 1'b0, 32'd0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("reset_drops_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_clears_inhibit", {29'd0, cnt_enable}, 32'd7);
        sb.delete();
        model_reset();
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, req_ready}, 32'd1);
        do_req(12'hC81, 1'b0, 32'd0, 1);
        do_req(12'h320, 1'b0, 32'd0, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perf_csr_port.md
Name: perf_csr_port

Overview:
- CSR-side consumer of the performance counter instances. Presents their 32-bit low/high halves on the unprivileged counter CSR addresses and owns the mcountinhibit register that drives each counter's enable input.
- Sits between the CSR execute path (request/response handshake) and the counter bank.
- Latches a high-half shadow on low-half reads, so software doing a lo/hi read pair gets a consistent 64-bit value.

Parameters:
- NUM_CNT, 3: number of attached counters; index 0 = cycle, 1 = time, 2 = instret, 3+ = hpmcounter3+. Legal range 3..32.
- XLEN, 32: CSR data width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  global clock enable; all state advances only when high
- cnt_lo  in  NUM_CNT x XLEN  low halves (outL) of each counter
- cnt_hi  in  NUM_CNT x XLEN  high halves (outH) of each counter
- cnt_enable  out  NUM_CNT  enable to each counter; bit i = ~inhibit[i]
- req_valid  in  1  CSR request valid
- req_ready  out  1  port can accept a request
- req_addr  in  12  CSR address
- req_we  in  1  1 = write, 0 = read
- req_wdata  in  XLEN  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  XLEN  read data (0 on writes and on errors)
- rsp_err  out  1  illegal access

Behaviour:
- Reset values:
  - state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0.
  - inhibit=0, so cnt_enable all 1.
  - shadow_hi all 0; shadow_vld all 0.
- FSM has two states, IDLE and RESP. req_ready = (state==IDLE).
- Accept: req_valid & req_ready & clk_en at a rising edge.
  - On accept, decode and register the response; state moves to RESP.
  - rsp_valid=1 from the next cycle. Latency is exactly 1 cycle.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready & clk_en, then return to IDLE.
  - No back-to-back accept in the same cycle; the minimum request spacing is 2 cycles.
- clk_en=0: the FSM, registers and shadow state freeze. cnt_enable stays combinational from inhibit.
- Address decode, with i < NUM_CNT:
  - 0xC00+i read: rdata = cnt_lo[i] sampled at the accept edge. Also sets shadow_hi[i]=cnt_hi[i] (same edge) and shadow_vld[i]=1.
  - 0xC80+i read: rdata = shadow_hi[i] if shadow_vld[i], else cnt_hi[i]. Clears shadow_vld[i].
  - 0x320 read: rdata = inhibit, zero-extended. Bits >= NUM_CNT read 0; bit 1 always reads 0.
  - 0x320 write: inhibit <= req_wdata[NUM_CNT-1:0], with bit 1 forced 0 (the time counter cannot be inhibited). Takes effect on cnt_enable the cycle after accept.
  - Any write to 0xC00–0xC9F: rsp_err=1, no state change, shadow unaffected.
  - Any other address, including 0xC00+i with i >= NUM_CNT: rsp_err=1, rdata=0.
- Shadow rules:
  - A second low read of the same counter overwrites its shadow.
  - A low read of counter j leaves counter k≠j untouched.
  - A high read without a preceding low read returns the live value.
- A write to 0x320 clears no shadows.
- Counter wrap: a low half wrapping 0xFFFFFFFF→0 between the lo and hi reads must still return the pre-wrap high half from the shadow.
- Reset mid-operation (asserted in RESP):
  - rsp_valid drops immediately (asynchronous); the pending response is lost.
  - inhibit and shadows clear.

Test Plan:
- Reset, then read 0x320 -> rsp_valid one cycle after accept; rdata=0, err=0; cnt_enable=3'b111.
- Write 0x320 with 0xFFFFFFFF (NUM_CNT=3) -> next cycle cnt_enable=3'b010. A read-back of 0x320 returns 0x00000005.
- cnt_lo[0]=0xFFFFFFFF, cnt_hi[0]=0x00000007 at the 0xC00 read; counter then wraps to hi=8; read 0xC80 -> first rdata=0xFFFFFFFF, second rdata=0x00000007. An immediate second 0xC80 read returns live 0x00000008.
- Write to 0xC02, then read 0xC05 with NUM_CNT=3 -> both rsp_err=1 and rdata=0; inhibit is unchanged.
- Hold rsp_ready=0 for 5 cycles while cnt_lo changes -> rsp_rdata stays stable and req_ready=0 throughout. Accept occurs only after rsp_ready pulses.
- clk_en=0 during an accept attempt -> no response. Assert rst_n=0 while in RESP -> rsp_valid=0 immediately, req_ready=1 after release.
